// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: blanking levels,
// the hex-to-segment table and a counter width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low codes for 0..F; element [n] is digit n, bit7 (dp) left dark.
    localparam logic [15:0][7:0] HEX_CODES = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic int width_of(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with decimal point, active-low
// outputs for a common-anode display.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] code
);

    always_comb begin
        code = {~dp, HEX_CODES[nibble][6:0]};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-aligned
// shadow updates. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int PW = width_of(REFRESH_DIV);
    localparam int IW = width_of(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    pend_value_q, pend_value_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]      pend_en_q, pend_en_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]    disp_value_q, disp_value_d;
    logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]      disp_en_q, disp_en_d;
    logic [7:0]             seg_q, seg_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   frame_tick_q, frame_tick_d;

    logic                   presc_wrap;
    logic                   frame_end;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_en;
    logic                   cur_blank;
    logic [DIGITS-1:0]      lz_blank;
    logic [7:0]             dec_code;

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .code   (dec_code)
    );

    always_comb begin
        presc_wrap   = (presc_q == PRESC_LAST);
        frame_end    = presc_wrap && (idx_q == IDX_LAST);
        presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        frame_tick_d = frame_end;
        if (presc_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // A load landing on the frame boundary bypasses pending and shows at once.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        disp_value_d = disp_value_q;
        disp_dp_d    = disp_dp_q;
        disp_en_d    = disp_en_q;
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
        if (frame_end) begin
            pend_valid_d = 1'b0;
            if (load) begin
                disp_value_d = value;
                disp_dp_d    = dp_in;
                disp_en_d    = digit_en;
            end else if (pend_valid_q) begin
                disp_value_d = pend_value_q;
                disp_dp_d    = pend_dp_q;
                disp_en_d    = pend_en_q;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk from the most significant digit; the run stops at the first non-zero nibble.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_value_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run && (i != 0) && !disp_dp_q[i];
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_value_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_en    = disp_en_q[i];
                cur_blank = lz_blank[i];
            end
        end
        seg_d = SEG_OFF;
        an_d  = AN_OFF[DIGITS-1:0];
        if (cur_en && !cur_blank) begin
            seg_d = dec_code;
            if (presc_q >= BLANK_END) begin
                an_d = ~(DIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF[DIGITS-1:0];
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1) against a cycle-position reference model.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 1;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int checks;
    int errors;
    int cycNum;
    int ticks;

    logic        mPendValid;
    logic [15:0] mPendVal;
    logic [3:0]  mPendDp;
    logic [3:0]  mPendEn;
    logic [15:0] mDispVal;
    logic [3:0]  mDispDp;
    logic [3:0]  mDispEn;
    logic [7:0]  expSeg;
    logic [3:0]  expAn;
    logic        expTick;

    seg7_scan_driver #(
        .DIGITS       (D),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] decodeRef(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Output after an edge depends on the slot position before it; the
    // position is simply the number of clocks since reset.
    task automatic modelStep();
        int pos;
        int dig;
        logic boundary;
        logic lit;
        logic [3:0] nib;
        if (rst) begin
            cycNum     = 0;
            mPendValid = 1'b0;
            mPendVal   = '0;
            mPendDp    = '0;
            mPendEn    = '0;
            mDispVal   = '0;
            mDispDp    = '0;
            mDispEn    = '0;
            expSeg     = 8'hFF;
            expAn      = 4'hF;
            expTick    = 1'b0;
            return;
        end
        pos      = cycNum % R;
        dig      = (cycNum / R) % D;
        boundary = (cycNum % (R * D)) == (R * D - 1);
        nib      = 4'((mDispVal >> (4 * dig)) & 16'h000F);
        lit      = mDispEn[dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig != 0 && !mDispDp[dig] && (mDispVal >> (4 * dig)) == 16'h0000) lit = 1'b0;
`endif
        expSeg = 8'hFF;
        expAn  = 4'hF;
        if (lit) begin
            expSeg = decodeRef(nib) & (mDispDp[dig] ? 8'h7F : 8'hFF);
            if (pos >= B) expAn[dig] = 1'b0;
        end
        expTick = boundary;
        if (boundary && load) begin
            mDispVal   = value;
            mDispDp    = dp_in;
            mDispEn    = digit_en;
            mPendValid = 1'b0;
        end else if (boundary && mPendValid) begin
            mDispVal   = mPendVal;
            mDispDp    = mPendDp;
            mDispEn    = mPendEn;
            mPendValid = 1'b0;
        end else if (load) begin
            mPendVal   = value;
            mPendDp    = dp_in;
            mPendEn    = digit_en;
            mPendValid = 1'b1;
        end
        cycNum++;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (seg === expSeg) else begin
            errors++;
            $error("[TB] FAIL %s seg: got %h expected %h (cycle %0d)", tag, seg, expSeg, cycNum);
        end
        checks++;
        assert (an === expAn) else begin
            errors++;
            $error("[TB] FAIL %s an: got %b expected %b (cycle %0d)", tag, an, expAn, cycNum);
        end
        checks++;
        assert (frame_tick === expTick) else begin
            errors++;
            $error("[TB] FAIL %s frame_tick: got %b expected %b (cycle %0d)", tag, frame_tick, expTick, cycNum);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                                 input logic [3:0] dpv, input logic [3:0] env, input string tag);
        rst      = r;
        load     = l;
        value    = v;
        dp_in    = dpv;
        digit_en = env;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    // Idle cycles carry random data on the ports to prove it is ignored without load.
    task automatic runIdle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), tag);
        end
    endtask

    task automatic waitPhase(input int phase, input string tag);
        for (int i = 0; i < R * D && (cycNum % (R * D)) != phase; i++) begin
            runIdle(1, tag);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cycNum   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        digit_en = '0;
        $display("[TB] seg7_scan_driver bench starting");

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'hF, 4'hF, "reset");
        runIdle(20, "dark_after_reset");

        applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF, "load_1234");
        runIdle(32, "scan_1234_settle");
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            runIdle(1, "scan_1234");
            if (frame_tick) ticks++;
        end
        checks++;
        assert (ticks == 2) else begin
            errors++;
            $error("[TB] FAIL tick_rate: got %0d pulses expected 2 in 32 cycles", ticks);
        end

        waitPhase(6, "to_mid_frame");
        applyStimulus(1'b0, 1'b1, 16'hABCD, 4'h0, 4'hF, "load_abcd_mid");
        runIdle(40, "tear_free_abcd");

        waitPhase(3, "to_phase3");
        applyStimulus(1'b0, 1'b1, 16'h5555, 4'h0, 4'hF, "load_5555");
        waitPhase(15, "to_boundary");
        applyStimulus(1'b0, 1'b1, 16'h0F00, 4'h0, 4'hF, "load_0f00_boundary");
        runIdle(40, "show_0f00");

        waitPhase(5, "to_phase5");
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF, "b2b_first");
        applyStimulus(1'b0, 1'b1, 16'h2222, 4'h3, 4'hF, "b2b_second");
        runIdle(40, "b2b_last_wins");

        applyStimulus(1'b0, 1'b1, 16'h8888, 4'b0001, 4'b0101, "load_en_dp");
        runIdle(40, "en_dp_8888");

        applyStimulus(1'b0, 1'b1, 16'h0007, 4'h0, 4'hF, "load_0007");
        runIdle(40, "show_0007");
        applyStimulus(1'b0, 1'b1, 16'h0000, 4'h0, 4'hF, "load_0000");
        runIdle(40, "show_0000");

        waitPhase(9, "to_phase9");
        applyStimulus(1'b0, 1'b1, 16'h5A5A, 4'hF, 4'hF, "load_before_reset");
        applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, "reset_mid_frame");
        runIdle(40, "pending_discarded");

        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 249) == 0), ($urandom_range(0, 7) == 0),
                          16'($urandom), 4'($urandom), 4'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
